// File: rtl/im_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory fetch controller.
//   state_e        : controller state encoding, visible on state_o
//   DefaultResetPc : byte PC loaded by reset unless overridden
//   align_pc       : clears the byte-offset bits of a PC
package im_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/im_fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its neighbours.
//   Fetch slot : if_valid, if_inst, if_pc (to decode); id_ready (from decode)
//   ROM        : rom_addr (to ROM); rom_data (combinational read data)
//   Debug port : dbg_req, dbg_addr (from board); dbg_gnt, dbg_data (to board)
// master = fetch controller, slave = the surrounding CPU/board side.
interface im_fetch_ctrl_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 10
);

  logic                 if_valid;
  logic [DataWidth-1:0] if_inst;
  logic [31:0]          if_pc;
  logic                 id_ready;

  logic [AddrWidth-1:0] rom_addr;
  logic [DataWidth-1:0] rom_data;

  logic                 dbg_req;
  logic [AddrWidth-1:0] dbg_addr;
  logic                 dbg_gnt;
  logic [DataWidth-1:0] dbg_data;

  modport master (
    output if_valid, if_inst, if_pc, rom_addr, dbg_gnt, dbg_data,
    input  id_ready, rom_data, dbg_req, dbg_addr
  );

  modport slave (
    input  if_valid, if_inst, if_pc, rom_addr, dbg_gnt, dbg_data,
    output id_ready, rom_data, dbg_req, dbg_addr
  );

endinterface

// File: rtl/im_fetch_ctrl_dbg_arb.sv
// Debug-read arbiter sharing the instruction ROM with the fetch path.
// Ports:
//   clk_i, rst_ni   : clock; synchronous active-low reset
//   dbg_req_i/addr_i: board read request (held until grant) and word index
//   need_i          : fetch path wants the ROM this cycle
//   pc_word_i       : fetch word index
//   rom_data_i      : combinational ROM read data
//   rom_addr_o      : muxed ROM address
//   steal_o         : debug takes this cycle from a wanting fetch path
//   dbg_gnt_o       : one-cycle grant, dbg_data_o valid with it
module im_fetch_ctrl_dbg_arb #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 10,
  parameter int unsigned DbgMaxWait = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dbg_req_i,
  input  logic [AddrWidth-1:0] dbg_addr_i,
  input  logic                 need_i,
  input  logic [AddrWidth-1:0] pc_word_i,
  input  logic [DataWidth-1:0] rom_data_i,
  output logic [AddrWidth-1:0] rom_addr_o,
  output logic                 steal_o,
  output logic                 dbg_gnt_o,
  output logic [DataWidth-1:0] dbg_data_o
);

  localparam int unsigned CntW = (DbgMaxWait < 1) ? 1 : $clog2(DbgMaxWait + 1);
  localparam logic [CntW-1:0] WaitMax = CntW'(DbgMaxWait);

  logic [CntW-1:0]      wait_q, wait_d;
  logic                 dbg_gnt_q;
  logic [DataWidth-1:0] dbg_data_q;
  logic                 dbg_sel;

  // Starved long enough: take the ROM even though fetch wants it.
  assign steal_o    = dbg_req_i && (wait_q == WaitMax);
  assign dbg_sel    = dbg_req_i && (!need_i || steal_o);
  assign rom_addr_o = dbg_sel ? dbg_addr_i : pc_word_i;
  assign dbg_gnt_o  = dbg_gnt_q;
  assign dbg_data_o = dbg_data_q;

  always_comb begin
    wait_d = '0;
    if (dbg_sel) begin
      wait_d = '0;
    end else if (dbg_req_i) begin
      wait_d = (wait_q == WaitMax) ? wait_q : wait_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_q     <= '0;
      dbg_gnt_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      wait_q    <= wait_d;
      dbg_gnt_q <= dbg_sel;
      if (dbg_sel) begin
        dbg_data_q <= rom_data_i;
      end
    end
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the instruction ROM and
// registers {pc, inst} into a valid/ready slot for decode.
// Ports:
//   clk, rst_n      : clock; synchronous active-low reset
//   start, halt_req : run control pulses (halt wins when both are high)
//   redirect_valid/redirect_pc : branch/jump target, flushes the slot
//   bus             : slot, ROM and debug-port signals (master side)
//   state_o         : 0 idle, 1 run, 2 halted
//   fetch_cnt       : instructions delivered to the slot since reset
//   misalign_err    : one-cycle pulse on a redirect with nonzero byte offset
module im_fetch_ctrl
  import im_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 10,
  parameter logic [31:0] ResetPc    = DefaultResetPc,
  parameter int unsigned DbgMaxWait = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  im_fetch_ctrl_if.master        bus,
  output logic [1:0]             state_o,
  output logic [31:0]            fetch_cnt,
  output logic                   misalign_err
);

  state_e               state_q, state_d;
  logic [31:0]          pc_q;
  logic                 valid_q;
  logic [DataWidth-1:0] inst_q;
  logic [31:0]          if_pc_q;
  logic [31:0]          cnt_q;
  logic                 misalign_q;

  logic                 need;
  logic                 steal;
  logic                 fetch_fire;

  assign need       = (state_q == StRun) && (!valid_q || bus.id_ready);
  assign fetch_fire = need && !steal && !redirect_valid && !halt_req;

  im_fetch_ctrl_dbg_arb #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth),
    .DbgMaxWait(DbgMaxWait)
  ) u_dbg_arb (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .dbg_req_i (bus.dbg_req),
    .dbg_addr_i(bus.dbg_addr),
    .need_i    (need),
    .pc_word_i (pc_q[AddrWidth+1:2]),
    .rom_data_i(bus.rom_data),
    .rom_addr_o(bus.rom_addr),
    .steal_o   (steal),
    .dbg_gnt_o (bus.dbg_gnt),
    .dbg_data_o(bus.dbg_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start && !halt_req) state_d = StRun;
      StRun:    if (halt_req)           state_d = StHalted;
      StHalted: if (start && !halt_req) state_d = StRun;
      default:                          state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= ResetPc;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      if_pc_q    <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= redirect_valid && (|redirect_pc[1:0]);
      // Redirect beats fetch; a slot that is neither refilled nor held drains.
      if (redirect_valid) begin
        pc_q    <= align_pc(redirect_pc);
        valid_q <= 1'b0;
      end else if (fetch_fire) begin
        inst_q  <= bus.rom_data;
        if_pc_q <= pc_q;
        valid_q <= 1'b1;
        pc_q    <= pc_q + 32'd4;
        cnt_q   <= cnt_q + 32'd1;
      end else if (valid_q && bus.id_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.if_valid = valid_q;
  assign bus.if_inst  = inst_q;
  assign bus.if_pc    = if_pc_q;
  assign state_o      = state_q;
  assign fetch_cnt    = cnt_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Scoreboard bench for im_fetch_ctrl. ROM modelled as rom[i] = 32'hA000_0000 + i.
module tb_im_fetch_ctrl;

  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 10;
  localparam int unsigned MaxWait = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  state_o;
  logic [31:0] fetch_cnt;
  logic        misalign_err;

  im_fetch_ctrl_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

  im_fetch_ctrl #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .ResetPc   (32'h0),
    .DbgMaxWait(MaxWait)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt_req      (halt_req),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bus           (bus),
    .state_o       (state_o),
    .fetch_cnt     (fetch_cnt),
    .misalign_err  (misalign_err)
  );

  assign bus.rom_data = 32'hA000_0000 + 32'(bus.rom_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [63:0] slot_q[$];
  logic [31:0] dbg_q[$];
  bit          mis_q[$];

  function automatic logic [63:0] slot_exp(input logic [31:0] pc);
    return {pc, 32'hA000_0000 + 32'(pc[AW+1:2])};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_slots(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) slot_q.push_back(slot_exp(first + 32'(4 * i)));
  endtask

  task automatic wait_gnt(input string name, input int exp_cycles);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      tick();
      n++;
      if (bus.dbg_gnt === 1'b1) begin
        got         = 1'b1;
        bus.dbg_req = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s actual no_grant required grant", name);
    end else begin
      check(name, 32'(n), 32'(exp_cycles));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
    check({tag, "_inst"},  bus.if_inst,       32'd0);
    check({tag, "_pc"},    bus.if_pc,         32'd0);
    check({tag, "_gnt"},   32'(bus.dbg_gnt),  32'd0);
    check({tag, "_ddata"}, bus.dbg_data,      32'd0);
    check({tag, "_state"}, 32'(state_o),      32'd0);
    check({tag, "_cnt"},   fetch_cnt,         32'd0);
    check({tag, "_mis"},   32'(misalign_err), 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a slot handshake,
  // a debug grant or a misalignment pulse.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    logic [31:0] d;
    if (bus.if_valid === 1'b1 && bus.id_ready === 1'b1) begin
      checks++;
      if (slot_q.size() == 0) begin
        errors++;
        $display("FAIL slot_unexpected actual pc %h inst %h required none",
                 bus.if_pc, bus.if_inst);
      end else begin
        e = slot_q.pop_front();
        if ({bus.if_pc, bus.if_inst} !== e) begin
          errors++;
          $display("FAIL slot actual pc %h inst %h required pc %h inst %h",
                   bus.if_pc, bus.if_inst, e[63:32], e[31:0]);
        end
      end
    end
    if (bus.dbg_gnt === 1'b1) begin
      checks++;
      if (dbg_q.size() == 0) begin
        errors++;
        $display("FAIL dbg_unexpected actual %h required none", bus.dbg_data);
      end else begin
        d = dbg_q.pop_front();
        if (bus.dbg_data !== d) begin
          errors++;
          $display("FAIL dbg_data actual %h required %h", bus.dbg_data, d);
        end
      end
    end
    if (misalign_err === 1'b1) begin
      checks++;
      if (mis_q.size() == 0) begin
        errors++;
        $display("FAIL misalign_unexpected actual 1 required 0");
      end else begin
        void'(mis_q.pop_front());
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bus.id_ready   = 1'b0;
    bus.dbg_req    = 1'b0;
    bus.dbg_addr   = '0;
    tick();
    tick();
    check_reset("rst");
    check("rst_romaddr", 32'(bus.rom_addr), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_state", 32'(state_o), 32'd0);
    check("idle_valid", 32'(bus.if_valid), 32'd0);

    // Streaming from reset PC
    push_slots(32'h0, 5);
    start        = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    start = 1'b0;
    check("start_state", 32'(state_o), 32'd1);
    check("start_valid", 32'(bus.if_valid), 32'd0);
    tick();
    check("first_pc",   bus.if_pc,   32'h0);
    check("first_inst", bus.if_inst, 32'hA000_0000);
    check("first_cnt",  fetch_cnt,   32'd1);
    tick();
    tick();
    tick();
    check("stream_pc",  bus.if_pc, 32'hC);
    check("stream_cnt", fetch_cnt, 32'd4);

    // Decode stall for three cycles
    bus.id_ready = 1'b0;
    tick();
    tick();
    tick();
    check("stall_pc",    bus.if_pc,              32'hC);
    check("stall_inst",  bus.if_inst,            32'hA000_0003);
    check("stall_valid", 32'(bus.if_valid),      32'd1);
    check("stall_cnt",   fetch_cnt,              32'd4);
    check("stall_pcreg", 32'(bus.rom_addr),      32'd4);
    bus.id_ready = 1'b1;
    tick();
    check("release_pc",  bus.if_pc, 32'h10);
    check("release_cnt", fetch_cnt, 32'd5);

    // Aligned redirect flushes the slot
    push_slots(32'h40, 2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush",   32'(bus.if_valid), 32'd0);
    check("redir_nomis",   32'(misalign_err), 32'd0);
    check("redir_romaddr", 32'(bus.rom_addr), 32'h10);
    tick();
    check("redir_pc",   bus.if_pc,   32'h40);
    check("redir_inst", bus.if_inst, 32'hA000_0010);
    tick();
    check("redir_next", bus.if_pc, 32'h44);

    // Misaligned redirect
    push_slots(32'h40, 1);
    mis_q.push_back(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    redirect_valid = 1'b0;
    check("mis_pulse", 32'(misalign_err),   32'd1);
    check("mis_flush", 32'(bus.if_valid),   32'd0);
    tick();
    check("mis_clear", 32'(misalign_err), 32'd0);
    check("mis_pc",    bus.if_pc,         32'h40);
    check("mis_cnt",   fetch_cnt,         32'd8);

    // Halt: slot drains, no fetch, pc retained
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_state", 32'(state_o),      32'd2);
    check("halt_drain", 32'(bus.if_valid), 32'd0);
    check("halt_cnt",   fetch_cnt,         32'd8);
    tick();
    check("halted_valid",   32'(bus.if_valid), 32'd0);
    check("halted_cnt",     fetch_cnt,         32'd8);
    check("halted_romaddr", 32'(bus.rom_addr), 32'h11);

    // Debug read while halted: immediate grant
    dbg_q.push_back(32'hA000_0005);
    bus.dbg_addr = 10'd5;
    bus.dbg_req  = 1'b1;
    #1;
    check("dbg_romaddr", 32'(bus.rom_addr), 32'd5);
    wait_gnt("dbg_halted_lat", 1);
    tick();
    check("dbg_gnt_single", 32'(bus.dbg_gnt), 32'd0);
    check("dbg_state",      32'(state_o),     32'd2);

    // Resume at retained pc
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_state", 32'(state_o), 32'd1);
    push_slots(32'h44, 1);
    tick();
    check("resume_pc",  bus.if_pc, 32'h44);
    check("resume_cnt", fetch_cnt, 32'd9);

    // Debug read while streaming: starved then steals one slot
    push_slots(32'h48, 9);
    dbg_q.push_back(32'hA000_0003);
    bus.dbg_addr = 10'd3;
    bus.dbg_req  = 1'b1;
    wait_gnt("dbg_run_lat", MaxWait + 1);
    check("steal_bubble", 32'(bus.if_valid), 32'd0);
    check("steal_cnt",    fetch_cnt,         32'd17);
    tick();
    check("steal_after_pc",  bus.if_pc,        32'h68);
    check("steal_after_cnt", fetch_cnt,        32'd18);
    check("steal_gnt_low",   32'(bus.dbg_gnt), 32'd0);

    // Mid-stream reset with a debug request pending
    bus.id_ready = 1'b0;
    bus.dbg_addr = 10'd7;
    bus.dbg_req  = 1'b1;
    rst_n        = 1'b0;
    tick();
    slot_q.delete();
    check_reset("midrst");
    rst_n       = 1'b1;
    bus.dbg_req = 1'b0;
    tick();
    check("postrst_state",   32'(state_o),      32'd0);
    check("postrst_romaddr", 32'(bus.rom_addr), 32'd0);
    check("postrst_gnt",     32'(bus.dbg_gnt),  32'd0);
    tick();

    check("slot_q_left", 32'(slot_q.size()), 32'd0);
    check("dbg_q_left",  32'(dbg_q.size()),  32'd0);
    check("mis_q_left",  32'(mis_q.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
